matrix_ram_ctrl: RTL and testbench

MATRIX_RAM_CTRL -- requirements
Module: matrix_ram_ctrl

---
 rtl/matrix_ram_pkg.sv | 15 +
 rtl/matrix_ram_store.sv | 44 ++++
 rtl/matrix_ram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_matrix_ram_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_ram_pkg.sv
// Shared types and helpers for the matrix RAM controller.
// Holds the controller state encoding and the index-width helper.
package matrix_ram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_ram_store.sv
// Cell storage: ROWS x COLS array, one byte-masked write port
// and one registered read port sharing the same address. No reset.
module matrix_ram_store #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 16,
    parameter int RW     = 3,
    parameter int CW     = 3,
    parameter int BE_W   = 2
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [RW-1:0]     i_row,
    input  logic [CW-1:0]     i_col,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [ROWS][COLS];
    logic [DATA_W-1:0] r_rdata;

    // Byte-masked write; caller guarantees the address is in range.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_row][i_col][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read: captures the cell as it was before this edge.
    always_ff @(posedge CLK) begin
        if (i_re) begin
            r_rdata <= r_mem[i_row][i_col];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_ram_ctrl.sv
// Matrix RAM controller: zero-fill sweep after reset or CLEAR,
// then single-cycle request handling with range check and read response.
module matrix_ram_ctrl
    import matrix_ram_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 16,
    localparam int RW    = addr_w(ROWS),
    localparam int CW    = addr_w(COLS),
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLEAR,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [RW-1:0]     ROW,
    input  logic [CW-1:0]     COLUMN,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [BE_W-1:0]   WR_BE,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_ERR,
    output logic              BUSY
);

    localparam int RW1 = RW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [RW:0]   ROWS_L   = RW1'(ROWS);
    localparam logic [CW:0]   COLS_L   = CW1'(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [RW-1:0]     r_swp_row;
    logic [RW-1:0]     w_swp_row_nxt;
    logic [CW-1:0]     r_swp_col;
    logic [CW-1:0]     w_swp_col_nxt;

    logic              w_in_range;
    logic              w_accept;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_swp_last;

    logic              w_mem_we;
    logic              w_mem_re;
    logic [RW-1:0]     w_mem_row;
    logic [CW-1:0]     w_mem_col;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [BE_W-1:0]   w_mem_be;
    logic [DATA_W-1:0] w_mem_q;

    logic              r_rd_valid;
    logic              r_rd_err;
    logic              r_rd_zero;

    // A CLEAR in RUN wins over a request presented in the same cycle.
    assign REQ_READY  = (r_state == RUN) && !CLEAR;
    assign BUSY       = (r_state == SWEEP);
    assign w_in_range = ({1'b0, ROW} < ROWS_L) && ({1'b0, COLUMN} < COLS_L);
    assign w_accept   = REQ_VALID && REQ_READY;
    assign w_rd_acc   = w_accept && !REQ_WRITE;
    assign w_wr_acc   = w_accept && REQ_WRITE && w_in_range;
    assign w_swp_last = (r_swp_row == ROW_LAST) && (r_swp_col == COL_LAST);
    assign w_mem_re   = w_rd_acc && w_in_range;

    // State and sweep-counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= SWEEP;
            r_swp_row <= '0;
            r_swp_col <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_swp_row <= w_swp_row_nxt;
            r_swp_col <= w_swp_col_nxt;
        end
    end

    // Next state, sweep advance and storage port steering.
    always_comb begin
        w_state_nxt   = r_state;
        w_swp_row_nxt = r_swp_row;
        w_swp_col_nxt = r_swp_col;
        w_mem_we      = 1'b0;
        w_mem_row     = ROW;
        w_mem_col     = COLUMN;
        w_mem_wdata   = WR_DATA;
        w_mem_be      = WR_BE;
        unique case (r_state)
            SWEEP: begin
                w_mem_we    = 1'b1;
                w_mem_row   = r_swp_row;
                w_mem_col   = r_swp_col;
                w_mem_wdata = '0;
                w_mem_be    = '1;
                if (w_swp_last) begin
                    w_state_nxt   = RUN;
                    w_swp_row_nxt = '0;
                    w_swp_col_nxt = '0;
                end else if (r_swp_col == COL_LAST) begin
                    w_swp_col_nxt = '0;
                    w_swp_row_nxt = r_swp_row + 1'b1;
                end else begin
                    w_swp_col_nxt = r_swp_col + 1'b1;
                end
            end
            RUN: begin
                w_mem_we = w_wr_acc;
                if (CLEAR) begin
                    w_state_nxt   = SWEEP;
                    w_swp_row_nxt = '0;
                    w_swp_col_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = SWEEP;
            end
        endcase
    end

    // Read response strobe; r_rd_zero masks data for out-of-range reads
    // and keeps RD_DATA at zero until the first in-range read.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_rd_err   <= w_rd_acc && !w_in_range;
            if (w_rd_acc) begin
                r_rd_zero <= !w_in_range;
            end
        end
    end

    assign RD_VALID = r_rd_valid;
    assign RD_ERR   = r_rd_err;
    assign RD_DATA  = r_rd_zero ? '0 : w_mem_q;

    matrix_ram_store #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DATA_W),
        .RW     (RW),
        .CW     (CW),
        .BE_W   (BE_W)
    ) u_store (
        .CLK     (CLK),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_row   (w_mem_row),
        .i_col   (w_mem_col),
        .i_wdata (w_mem_wdata),
        .i_be    (w_mem_be),
        .o_rdata (w_mem_q)
    );

endmodule

// File: tb/tb_matrix_ram_ctrl.sv
// Bench for matrix_ram_ctrl: an 8x8 and a 6x5 instance checked
// against an array model, with directed tables and random traffic.
module tb_matrix_ram_ctrl;

    logic        CLK;
    logic        RST;
    logic        clr_i [2];
    logic        vld_i [2];
    logic        wr_i  [2];
    logic [2:0]  row_i [2];
    logic [2:0]  col_i [2];
    logic [15:0] dat_i [2];
    logic [1:0]  be_i  [2];
    logic        rdy_o [2];
    logic        busy_o[2];
    logic        rv_o  [2];
    logic        re_o  [2];
    logic [15:0] rd_o  [2];

    matrix_ram_ctrl u_dut0 (
        .CLK(CLK), .RST(RST), .CLEAR(clr_i[0]),
        .REQ_VALID(vld_i[0]), .REQ_READY(rdy_o[0]),
        .REQ_WRITE(wr_i[0]), .ROW(row_i[0]), .COLUMN(col_i[0]),
        .WR_DATA(dat_i[0]), .WR_BE(be_i[0]),
        .RD_VALID(rv_o[0]), .RD_DATA(rd_o[0]),
        .RD_ERR(re_o[0]), .BUSY(busy_o[0])
    );

    matrix_ram_ctrl #(.ROWS(6), .COLS(5)) u_dut1 (
        .CLK(CLK), .RST(RST), .CLEAR(clr_i[1]),
        .REQ_VALID(vld_i[1]), .REQ_READY(rdy_o[1]),
        .REQ_WRITE(wr_i[1]), .ROW(row_i[1]), .COLUMN(col_i[1]),
        .WR_DATA(dat_i[1]), .WR_BE(be_i[1]),
        .RD_VALID(rv_o[1]), .RD_DATA(rd_o[1]),
        .RD_ERR(re_o[1]), .BUSY(busy_o[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: cell arrays, remaining sweep cycles, expected response.
    int          nrows[2] = '{8, 6};
    int          ncols[2] = '{8, 5};
    int          sl[2];
    logic [15:0] mem[2][8][8];
    logic        ev[2];
    logic        ee[2];
    logic [15:0] ed[2];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int       k;
        bit       v;
        bit       w;
        bit [2:0] r;
        bit [2:0] c;
        bit [15:0] d;
        bit [1:0] be;
        bit       xv;
        bit [15:0] xd;
        bit       xe;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input int j,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, j, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int j = 0; j < 2; j++) begin
            clr_i[j] = 1'b0;
            vld_i[j] = 1'b0;
            wr_i[j]  = 1'b0;
            row_i[j] = '0;
            col_i[j] = '0;
            dat_i[j] = '0;
            be_i[j]  = '0;
        end
    endtask

    task automatic model_edge(input int j);
        bit acc;
        bit inr;
        acc = vld_i[j] && (sl[j] == 0) && !clr_i[j];
        inr = (int'(row_i[j]) < nrows[j]) && (int'(col_i[j]) < ncols[j]);
        ev[j] = 1'b0;
        ee[j] = 1'b0;
        if (acc && !wr_i[j]) begin
            ev[j] = 1'b1;
            if (inr) begin
                ed[j] = mem[j][row_i[j]][col_i[j]];
            end else begin
                ed[j] = 16'h0;
                ee[j] = 1'b1;
            end
        end
        if (acc && wr_i[j] && inr) begin
            for (int b = 0; b < 2; b++) begin
                if (be_i[j][b]) begin
                    mem[j][row_i[j]][col_i[j]][b*8 +: 8] = dat_i[j][b*8 +: 8];
                end
            end
        end
        if (sl[j] > 0) begin
            sl[j]--;
        end else if (clr_i[j]) begin
            sl[j] = nrows[j] * ncols[j];
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem[j][r][c] = 16'h0;
        end
    endtask

    // One clock cycle: drive dut k (other dut idle), check, advance model.
    task automatic step(input int k, input bit v, input bit w,
                        input bit [2:0] r, input bit [2:0] c,
                        input bit [15:0] d, input bit [1:0] be,
                        input bit clr);
        idle_all();
        clr_i[k] = clr;
        vld_i[k] = v;
        wr_i[k]  = w;
        row_i[k] = r;
        col_i[k] = c;
        dat_i[k] = d;
        be_i[k]  = be;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("req_ready", j, rdy_o[j], (sl[j] == 0) && !clr_i[j]);
            chk("busy", j, busy_o[j], sl[j] != 0);
        end
        @(posedge CLK);
        for (int j = 0; j < 2; j++) model_edge(j);
        @(negedge CLK);
        for (int j = 0; j < 2; j++) begin
            chk("rd_valid", j, rv_o[j], ev[j]);
            chk("rd_data", j, rd_o[j], ed[j]);
            chk("rd_err", j, re_o[j], ee[j]);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("rst_rd_valid", j, rv_o[j], 0);
            chk("rst_rd_data", j, rd_o[j], 0);
            chk("rst_rd_err", j, re_o[j], 0);
            chk("rst_ready", j, rdy_o[j], 0);
            chk("rst_busy", j, busy_o[j], 1);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        idle_all();
        for (int j = 0; j < 2; j++) begin
            sl[j] = nrows[j] * ncols[j];
            ev[j] = 1'b0;
            ee[j] = 1'b0;
            ed[j] = 16'h0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem[j][r][c] = 16'h0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        idle_all();
        do_reset();

        // Sweep after reset release lasts exactly 64 cycles on the 8x8 unit.
        cnt = 0;
        while (busy_o[0] && cnt < 200) begin
            cnt++;
            step(0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("sweep_len_reset", 0, cnt, 64);

        tbl[0]  = '{0, 1, 0, 7, 7, 16'h0000, 2'b00, 1, 16'h0000, 0};
        tbl[1]  = '{0, 1, 1, 2, 3, 16'hBEEF, 2'b11, 0, 16'h0000, 0};
        tbl[2]  = '{0, 1, 1, 2, 3, 16'h1200, 2'b10, 0, 16'h0000, 0};
        tbl[3]  = '{0, 1, 0, 2, 3, 16'h0000, 2'b00, 1, 16'h12EF, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h12EF, 0};
        tbl[5]  = '{1, 1, 0, 0, 0, 16'h0000, 2'b00, 1, 16'h0000, 0};
        tbl[6]  = '{1, 1, 1, 6, 0, 16'hFFFF, 2'b11, 0, 16'h0000, 0};
        tbl[7]  = '{1, 1, 0, 6, 0, 16'h0000, 2'b00, 1, 16'h0000, 1};
        tbl[8]  = '{1, 1, 0, 0, 0, 16'h0000, 2'b00, 1, 16'h0000, 0};
        tbl[9]  = '{1, 1, 1, 0, 4, 16'hA5A5, 2'b11, 0, 16'h0000, 0};
        tbl[10] = '{1, 1, 0, 0, 4, 16'h0000, 2'b00, 1, 16'hA5A5, 0};
        tbl[11] = '{1, 1, 0, 0, 5, 16'h0000, 2'b00, 1, 16'h0000, 1};
        tbl[12] = '{1, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0};
        tbl[13] = '{0, 1, 0, 2, 3, 16'h0000, 2'b00, 1, 16'h12EF, 0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].k, tbl[i].v, tbl[i].w, tbl[i].r, tbl[i].c,
                 tbl[i].d, tbl[i].be, 1'b0);
            chk($sformatf("tbl%0d_vld", i), tbl[i].k, rv_o[tbl[i].k], tbl[i].xv);
            chk($sformatf("tbl%0d_dat", i), tbl[i].k, rd_o[tbl[i].k], tbl[i].xd);
            chk($sformatf("tbl%0d_err", i), tbl[i].k, re_o[tbl[i].k], tbl[i].xe);
        end

        // CLEAR with a read presented: not accepted, 64-cycle sweep,
        // second CLEAR on sweep cycle 10 does not extend it.
        step(0, 1, 0, 2, 3, 16'h0, 2'b00, 1);
        chk("clr_no_resp", 0, rv_o[0], 0);
        cnt = 0;
        while (busy_o[0] && cnt < 200) begin
            cnt++;
            step(0, 0, 0, 0, 0, 0, 0, cnt == 10);
        end
        chk("sweep_len_clear", 0, cnt, 64);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                step(0, 1, 0, r[2:0], c[2:0], 0, 0, 0);
                chk("cleared_cell", 0, rd_o[0], 0);
            end
        end

        // Random traffic on both instances, including out-of-range
        // addresses on the 6x5 unit and occasional CLEAR pulses.
        repeat (600) begin
            step($urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 16'($urandom),
                 2'($urandom_range(0, 3)), $urandom_range(0, 149) == 0);
        end

        while (sl[0] != 0 || sl[1] != 0) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back reads, then reset in the middle of a read burst.
        step(0, 1, 1, 0, 0, 16'h1111, 2'b11, 0);
        step(0, 1, 1, 0, 1, 16'h2222, 2'b11, 0);
        step(0, 1, 1, 0, 2, 16'h3333, 2'b11, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("b2b_0", 0, {rv_o[0], rd_o[0]}, {1'b1, 16'h1111});
        step(0, 1, 0, 0, 1, 0, 0, 0);
        chk("b2b_1", 0, {rv_o[0], rd_o[0]}, {1'b1, 16'h2222});
        step(0, 1, 0, 0, 2, 0, 0, 0);
        chk("b2b_2", 0, {rv_o[0], rd_o[0]}, {1'b1, 16'h3333});
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_pre_vld", 0, rv_o[0], 1);
        vld_i[0] = 1'b1;
        wr_i[0]  = 1'b0;
        row_i[0] = 3'd0;
        col_i[0] = 3'd1;
        #2;
        do_reset();
        repeat (5) begin
            step(0, 1, 0, 0, 1, 0, 0, 0);
            chk("rst_no_resp", 0, rv_o[0], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
